// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage (package fetch_pkg).
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam int PC_STEP = 4;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    // Force a byte address onto a word boundary.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return a & ~(ADDR_W'(3));
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Bundle of the fetch stage's memory, decoder and redirect signals.
// master = fetch stage, slave = memory/decoder/control side.
// With FETCH_ALIGN_CHECK_EN defined the bundle also carries fetch_fault.
interface instruction_fetch_if;
    import fetch_pkg::*;

    logic                imem_req;
    logic [ADDR_W-1:0]   imem_addr;
    logic                imem_ready;
    logic [INSTR_W-1:0]  imem_rdata;
    logic [INSTR_W-1:0]  instr;
    logic [ADDR_W-1:0]   instr_pc;
    logic [ADDR_W-1:0]   instr_pc4;
    logic                instr_valid;
    logic                instr_ready;
    logic                redirect;
    logic [ADDR_W-1:0]   redirect_target;
`ifdef FETCH_ALIGN_CHECK_EN
    logic                fetch_fault;
`endif

    modport master (
        output imem_req, imem_addr, instr, instr_pc, instr_pc4, instr_valid,
`ifdef FETCH_ALIGN_CHECK_EN
        output fetch_fault,
`endif
        input  imem_ready, imem_rdata, instr_ready, redirect, redirect_target
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, instr_pc4, instr_valid,
`ifdef FETCH_ALIGN_CHECK_EN
        input  fetch_fault,
`endif
        output imem_ready, imem_rdata, instr_ready, redirect, redirect_target
    );

endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, imem req/ready reads, instruction register
// with valid/ready to the decoder, and jump/branch redirects.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect raises sticky
// fetch_fault and halts fetching until reset.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                clk,
    input  logic                reset_n,
    instruction_fetch_if.master bus
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    // Drives imem_addr; kept apart from pc so a redirect during an
    // outstanding request cannot disturb the address memory is serving.
    logic [ADDR_W-1:0]  fetch_addr_q, fetch_addr_d;
    logic               req_q, req_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic [ADDR_W-1:0]  instr_pc4_q, instr_pc4_d;
    logic               valid_q, valid_d;
    logic               fault_q, fault_d;
    logic [ADDR_W-1:0]  tgt;

    assign tgt = word_align(bus.redirect_target);

    // Next-state and next-output computation; redirect outranks handshakes.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        req_d        = req_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;
        instr_pc4_d  = instr_pc4_q;
        valid_d      = valid_q;
        fault_d      = fault_q;

        unique case (state_q)
            IDLE: begin
                state_d = REQ;
                req_d   = 1'b1;
                if (bus.redirect) begin
                    pc_d         = tgt;
                    fetch_addr_d = tgt;
                end else begin
                    fetch_addr_d = pc_q;
                end
            end
            REQ: begin
                if (bus.redirect) begin
                    pc_d = tgt;
                    if (bus.imem_ready) begin
                        // Response is stale; restart at the target right away.
                        fetch_addr_d = tgt;
                    end else begin
                        // Address must stay put until memory finishes.
                        state_d = DRAIN;
                    end
                end else if (bus.imem_ready) begin
                    instr_d     = bus.imem_rdata;
                    instr_pc_d  = pc_q;
                    instr_pc4_d = pc_q + ADDR_W'(PC_STEP);
                    pc_d        = pc_q + ADDR_W'(PC_STEP);
                    valid_d     = 1'b1;
                    req_d       = 1'b0;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (bus.redirect) begin
                    // Squash the held instruction even if it is being accepted.
                    valid_d      = 1'b0;
                    pc_d         = tgt;
                    fetch_addr_d = tgt;
                    req_d        = 1'b1;
                    state_d      = REQ;
                end else if (bus.instr_ready) begin
                    valid_d      = 1'b0;
                    fetch_addr_d = pc_q;
                    req_d        = 1'b1;
                    state_d      = REQ;
                end
            end
            DRAIN: begin
                // A redirect keeps us here even if memory answers this cycle;
                // the re-issued old address is drained and discarded too.
                if (bus.redirect) begin
                    pc_d = tgt;
                end else if (bus.imem_ready) begin
                    fetch_addr_d = pc_q;
                    state_d      = REQ;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

`ifdef FETCH_ALIGN_CHECK_EN
        // Misaligned redirect: latch the fault and park with no requests.
        if (fault_q || (bus.redirect && (bus.redirect_target[1:0] != 2'b00))) begin
            fault_d = 1'b1;
            state_d = IDLE;
            req_d   = 1'b0;
            valid_d = 1'b0;
        end
`endif
    end

    // State and output registers; async reset returns to the idle image.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            fetch_addr_q <= RESET_PC;
            req_q        <= 1'b0;
            instr_q      <= '0;
            instr_pc_q   <= '0;
            instr_pc4_q  <= '0;
            valid_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            req_q        <= req_d;
            instr_q      <= instr_d;
            instr_pc_q   <= instr_pc_d;
            instr_pc4_q  <= instr_pc4_d;
            valid_q      <= valid_d;
            fault_q      <= fault_d;
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = fetch_addr_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_pc4   = instr_pc4_q;
    assign bus.instr_valid = valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
    assign bus.fetch_fault = fault_q;
`else
    logic unused_fault;
    assign unused_fault = fault_q ^ fault_d;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random traffic,
// all checked against a transaction-level fetch model.
module tb_instruction_fetch;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    instruction_fetch_if f ();
    instruction_fetch_if f2 ();

    instruction_fetch dut (.clk(clk), .reset_n(reset_n), .bus(f.master));
    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (.clk(clk), .reset_n(reset_n), .bus(f2.master));

    int vectors = 0;
    int miscompares = 0;

    // Model: started = left reset idle; m_req = a read is outstanding;
    // m_stale = that read belongs to an abandoned path; m_valid = buffer full.
    bit          m_started, m_req, m_stale, m_valid;
    logic [31:0] m_addr, m_pc, m_instr, m_ipc, m_ipc4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_req = 0; m_stale = 0; m_valid = 0;
        m_addr = 32'h0; m_pc = 32'h0;
        m_instr = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0;
    endtask

    // Advance the model across one rising edge using the driven inputs.
    task automatic model_edge();
        logic [31:0] t;
        t = f.redirect_target & 32'hFFFF_FFFC;
        if (!m_started) begin
            m_started = 1;
            if (f.redirect) m_pc = t;
            m_req = 1; m_addr = m_pc;
        end else if (m_valid) begin
            if (f.redirect) begin
                m_valid = 0; m_pc = t; m_req = 1; m_addr = t;
            end else if (f.instr_ready) begin
                m_valid = 0; m_req = 1; m_addr = m_pc;
            end
        end else if (m_req) begin
            if (m_stale) begin
                if (f.redirect) m_pc = t;
                else if (f.imem_ready) begin m_stale = 0; m_addr = m_pc; end
            end else if (f.redirect) begin
                m_pc = t;
                if (f.imem_ready) m_addr = t;
                else m_stale = 1;
            end else if (f.imem_ready) begin
                m_instr = f.imem_rdata;
                m_ipc   = m_addr;
                m_ipc4  = m_addr + 32'd4;
                m_pc    = m_addr + 32'd4;
                m_valid = 1; m_req = 0;
            end
        end
    endtask

    task automatic compare();
        chk("imem_req",    {31'b0, f.imem_req},    {31'b0, m_req});
        chk("imem_addr",   f.imem_addr,            m_addr);
        chk("instr_valid", {31'b0, f.instr_valid}, {31'b0, m_valid});
        chk("instr",       f.instr,                m_instr);
        chk("instr_pc",    f.instr_pc,             m_ipc);
        chk("instr_pc4",   f.instr_pc4,            m_ipc4);
    endtask

    task automatic drive(input bit rdy, input logic [31:0] rd, input bit ir,
                         input bit rdr, input logic [31:0] tgt);
        f.imem_ready = rdy; f.imem_rdata = rd; f.instr_ready = ir;
        f.redirect = rdr; f.redirect_target = tgt;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    initial begin
        drive(0, 32'h0, 0, 0, 32'h0);
        f2.imem_ready = 1; f2.imem_rdata = 32'h0; f2.instr_ready = 1;
        f2.redirect = 0; f2.redirect_target = 32'h0;
        model_reset();
        #12;
        compare();
        chk("rst_addr2", f2.imem_addr, 32'hFFFF_FFFC);
        @(negedge clk) reset_n = 1'b1;

        // Zero-wait memory, two back-to-back fetches.
        drive(1, 32'h0000_0000, 1, 0, 32'h0);
        step();
        chk("first_addr", f.imem_addr, 32'h0);
        chk("wrap_addr0", f2.imem_addr, 32'hFFFF_FFFC);
        step();
        chk("first_pc", f.instr_pc, 32'h0);
        drive(1, 32'h8FE0_55A6, 1, 0, 32'h0);
        step();
        chk("second_addr", f.imem_addr, 32'h4);
        chk("wrap_addr1", f2.imem_addr, 32'h0);
        drive(1, 32'h8FE0_55A6, 0, 0, 32'h0);
        step();
        chk("second_instr", f.instr, 32'h8FE0_55A6);
        chk("second_pc4", f.instr_pc4, 32'h8);

        // Consumer stall for five cycles.
        for (int i = 0; i < 5; i++) begin
            drive(1, $urandom, 0, 0, 32'h0);
            step();
            chk("stall_req", {31'b0, f.imem_req}, 32'h0);
            chk("stall_pc", f.instr_pc, 32'h4);
        end

        // Three wait states, redirect on the first one.
        drive(0, 32'h0, 1, 0, 32'h0);
        step();
        drive(0, 32'h0, 0, 1, 32'h0000_0100);
        step();
        chk("drain_addr", f.imem_addr, 32'h8);
        drive(0, 32'h0, 0, 0, 32'h0);
        step();
        step();
        drive(1, 32'hDEAD_BEEF, 0, 0, 32'h0);
        step();
        chk("post_drain_addr", f.imem_addr, 32'h100);
        drive(1, 32'h1234_5678, 0, 0, 32'h0);
        step();
        chk("redir_pc", f.instr_pc, 32'h100);

        // Redirect in HOLD while the consumer accepts.
        drive(0, 32'h0, 1, 1, 32'h0000_0040);
        step();
        chk("squash_valid", {31'b0, f.instr_valid}, 32'h0);
        chk("squash_addr", f.imem_addr, 32'h40);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] t;
            t = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
            t = t & 32'hFFFF_FFFC;
`endif
            drive(($urandom_range(0, 2) != 0), $urandom, $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 9) == 0), t);
            step();
        end

        // Asynchronous reset while a request is outstanding.
        drive(0, 32'h0, 1, 0, 32'h0);
        step();
        step();
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("arst_req", {31'b0, f.imem_req}, 32'h0);
        chk("arst_addr", f.imem_addr, 32'h0);
        chk("arst_valid", {31'b0, f.instr_valid}, 32'h0);
        chk("arst_instr", f.instr, 32'h0);
        compare();
        @(negedge clk) reset_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            drive(($urandom_range(0, 1) == 1), $urandom, $urandom_range(0, 1) == 1,
                  0, 32'h0);
            step();
        end

`ifdef FETCH_ALIGN_CHECK_EN
        drive(0, 32'h0, 1, 1, 32'h0000_0102);
        @(posedge clk);
        #1;
        chk("fault", {31'b0, f.fetch_fault}, 32'h1);
        drive(1, 32'h0, 1, 0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("halt_req", {31'b0, f.imem_req}, 32'h0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of instructionDecoder in the multicycle MIPS CPU.
- Holds the PC and issues word reads to instruction memory with a req/ready handshake.
- Latches the returned word into an instruction register and drives it to the decoder's `instruction` input with a valid/ready handshake.
- Accepts jump/branch redirects from the control FSM.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- imem_req  out  1  read request to instruction memory
- imem_addr  out  32  word-aligned fetch address; stable while imem_req=1
- imem_ready  in  1  memory completes request this cycle
- imem_rdata  in  32  fetched word; valid when imem_ready=1
- instr  out  32  instruction register, drives decoder `instruction`
- instr_pc  out  32  address the word in instr was fetched from
- instr_pc4  out  32  instr_pc+4, for JAL link and branch base
- instr_valid  out  1  instr/instr_pc/instr_pc4 hold a live instruction
- instr_ready  in  1  consumer accepts instr this cycle
- redirect  in  1  one-cycle pulse: discard current fetch, restart at redirect_target
- redirect_target  in  32  new PC, sampled when redirect=1

Behaviour:
- Reset (async assert, sync release): state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr=0, instr_pc=0, instr_pc4=0, instr_valid=0.
- States:
  - IDLE: entered from reset only; next cycle goes to REQ.
  - REQ: imem_req=1, imem_addr=pc.
  - HOLD: instr_valid=1, imem_req=0.
  - DRAIN: imem_req=1, imem_addr=old fetch address; waits out an abandoned request.
- REQ transitions:
  - imem_ready=1, no redirect: instr<=imem_rdata, instr_pc<=pc, instr_pc4<=pc+4, pc<=pc+4, go to HOLD.
  - imem_ready=0: stay in REQ.
- HOLD transitions:
  - instr_ready=1: go to REQ (one bubble; max rate 1 instruction per 2 cycles with zero-wait memory).
  - instr_ready=0: stay in HOLD; instr, instr_pc and instr_pc4 hold their values.
- Latency: from reset release, imem_req rises on cycle 2. With imem_ready in the same cycle as imem_req, instr_valid rises the following cycle.
- Redirect has priority over everything except reset:
  - IDLE: pc<=redirect_target, go to REQ.
  - REQ with imem_ready=1 same cycle: discard rdata, instr unchanged, pc<=redirect_target, go to REQ.
  - REQ with imem_ready=0: the address must stay stable, so pc<=redirect_target and go to DRAIN. DRAIN holds the old imem_addr until imem_ready=1, discards the data, then goes to REQ at the new pc.
  - HOLD: instr_valid drops next cycle (instruction squashed even if instr_ready=1), pc<=redirect_target, go to REQ.
  - DRAIN: pc<=redirect_target, stay in DRAIN.
- Separate register fetch_addr drives imem_addr so it is independent of pc updates during DRAIN.
- Arithmetic: pc+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 32'h0000_0000. Low two bits of redirect_target are forced to 0.
- Reset mid-operation: immediate return to reset values. An outstanding memory response is ignored because state is IDLE.

Optional Feature:
- FETCH_ALIGN_CHECK_EN defined:
  - Adds output fetch_fault (1 bit, reset 0).
  - A redirect with redirect_target[1:0]!=0 sets fetch_fault=1 sticky until reset, and the block enters IDLE-like halt: no further imem_req.
- Not defined: no fetch_fault port; low bits silently masked as above.

Decomposition:
- Package fetch_pkg:
  - state enum {IDLE, REQ, HOLD, DRAIN}
  - INSTR_W=32, ADDR_W=32
  - PC_STEP=4
  - default RESET_PC constant
- No sub-module; PC increment and state machine are single-block.

Test Plan:
- Reset release, imem_ready tied 1, rdata=32'h0000_0000 then 32'h8FE0_55A6 → imem_addr 0 then 4; instr_valid high with instr_pc=0, then instr=32'h8FE0_55A6 with instr_pc=4, instr_pc4=8.
- instr_ready=0 for 5 cycles in HOLD → instr, instr_pc and instr_valid stable, imem_req=0 throughout.
- Memory with 3 wait states, redirect to 32'h0000_0100 on the first wait cycle → imem_addr stays at old value until ready, old data discarded, next request at 32'h100, first valid instr_pc=32'h100.
- Redirect to 32'h0000_0040 while in HOLD with instr_ready=1 → instruction not reissued, instr_valid low next cycle, next fetch at 32'h40.
- RESET_PC=32'hFFFF_FFFC → second fetch address 32'h0000_0000.
- Assert reset_n=0 mid-REQ → all outputs return to reset values without waiting for a clock edge; with FETCH_ALIGN_CHECK_EN, redirect to 32'h0000_0102 → fetch_fault=1, imem_req stays 0.
